// File: rtl/run_burst_pkg.sv
// Shared types and constants for the run_burst_gen serial burst generator.
package run_burst_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ONES,
      ZEROS,
      FIN
   } state_t;

   localparam int unsigned RUN_BURST_W_DEFAULT = 4;

endpackage

// File: rtl/burst_down_counter.sv
// Loadable W-bit down-counter with enable and zero flag; load has priority over enable.
module burst_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt - ONE;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/run_burst_gen.sv
// Serial burst generator: LEN ones then GAP zeros on a registered line, with start/busy/done.
// Optional back-to-back bursts via the REPEAT port when RUN_BURST_REPEAT_EN is defined.
module run_burst_gen
   import run_burst_pkg::*;
#(
   parameter int unsigned W = RUN_BURST_W_DEFAULT
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [W-1:0] LEN,
   input  logic [W-1:0] GAP,
   output logic         SOUT,
   output logic         BUSY,
   output logic         DONE
`ifdef RUN_BURST_REPEAT_EN
   ,
   input  logic         REPEAT
`endif
);

   localparam logic [W-1:0] ONE = W'(1);

   state_t       state;
   logic [W-1:0] len_q;
   logic [W-1:0] gap_q;
   logic         load;
   logic         en;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt;
   logic         zero;
   logic         again;
   logic         rep_in;

`ifdef RUN_BURST_REPEAT_EN
   logic rep_q;
   assign again  = rep_q;
   assign rep_in = REPEAT;
`else
   assign again  = 1'b0;
   assign rep_in = 1'b0;
`endif

   burst_down_counter #(.W(W)) u_cnt (
      .clk      (CLK),
      .rst      (RST),
      .load     (load),
      .en       (en),
      .load_val (load_val),
      .cnt      (cnt),
      .zero     (zero)
   );

   // Counter is reloaded on every phase entry so it never decrements past zero.
   always_comb begin
      load     = 1'b0;
      en       = 1'b0;
      load_val = '0;
      unique case (state)
         IDLE: begin
            if (START && (LEN != '0)) begin
               load     = 1'b1;
               load_val = LEN - ONE;
            end
         end
         ONES: begin
            if (!zero) begin
               en = 1'b1;
            end else if (gap_q != '0) begin
               load     = 1'b1;
               load_val = gap_q - ONE;
            end
         end
         ZEROS: begin
            en = !zero;
         end
         FIN: begin
            load     = again;
            load_val = len_q - ONE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         SOUT  <= 1'b0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         len_q <= '0;
         gap_q <= '0;
`ifdef RUN_BURST_REPEAT_EN
         rep_q <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START) begin
                  len_q <= LEN;
                  gap_q <= GAP;
                  BUSY  <= 1'b1;
                  if (LEN == '0) begin
                     state <= FIN;
                     DONE  <= 1'b1;
                     SOUT  <= 1'b0;
                  end else begin
                     state <= ONES;
                     SOUT  <= 1'b1;
                  end
               end
            end
            ONES: begin
               if (zero) begin
                  SOUT <= 1'b0;
`ifdef RUN_BURST_REPEAT_EN
                  rep_q <= rep_in;
`endif
                  if (gap_q != '0) begin
                     state <= ZEROS;
                  end else begin
                     state <= FIN;
                     DONE  <= 1'b1;
                  end
               end
            end
            ZEROS: begin
               if (zero) begin
                  state <= FIN;
                  DONE  <= 1'b1;
`ifdef RUN_BURST_REPEAT_EN
                  rep_q <= rep_in;
`endif
               end
            end
            FIN: begin
`ifdef RUN_BURST_REPEAT_EN
               rep_q <= 1'b0;
`endif
               if (again) begin
                  state <= ONES;
                  SOUT  <= 1'b1;
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = rep_in;

endmodule

// File: tb/tb_run_burst_gen.sv
// Scoreboard bench for run_burst_gen: expected {SOUT,BUSY,DONE} per cycle queued by stimulus, checked by a monitor.
module tb_run_burst_gen;

   localparam int unsigned W = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] LEN = '0;
   logic [W-1:0] GAP = '0;
   logic         SOUT;
   logic         BUSY;
   logic         DONE;
`ifdef RUN_BURST_REPEAT_EN
   logic         REPEAT = 1'b0;
`endif

   run_burst_gen #(.W(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .LEN   (LEN),
      .GAP   (GAP),
      .SOUT  (SOUT),
      .BUSY  (BUSY),
      .DONE  (DONE)
`ifdef RUN_BURST_REPEAT_EN
      ,
      .REPEAT(REPEAT)
`endif
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   logic [2:0] exp_q[$];

   // Loopback consecutive-ones detector: high once three or more ones have been seen in a row.
   int   run_len = 0;
   logic det = 1'b0;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         run_len <= 0;
         det     <= 1'b0;
      end else begin
         det     <= SOUT && (run_len >= 2);
         run_len <= SOUT ? ((run_len >= 7) ? 7 : run_len + 1) : 0;
      end
   end

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [2:0] v);
      exp_q.push_back(v);
   endtask

   task automatic push_n(input logic [2:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge CLK);
         t++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d pending required 0 pending", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: one expected {SOUT,BUSY,DONE} triple per cycle after each rising edge.
   initial begin
      logic [2:0] e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outs", {SOUT, BUSY, DONE}, e);
         end
      end
   end

   initial begin
      int n_det;
      @(negedge CLK);
      check("reset_state", {SOUT, BUSY, DONE}, 3'b000);
      RST = 1'b0;

      // Basic burst LEN=3 GAP=2.
      @(negedge CLK);
      LEN = 4'd3; GAP = 4'd2; START = 1'b1;
      push(3'b110); push(3'b110); push(3'b110);
      push(3'b010); push(3'b010); push(3'b011); push(3'b000);
      @(negedge CLK);
      START = 1'b0;
      wait_drain("basic");

      // LEN=0: immediate DONE, GAP ignored.
      LEN = 4'd0; GAP = 4'd7; START = 1'b1;
      push(3'b011); push(3'b000); push(3'b000);
      @(negedge CLK);
      START = 1'b0;
      wait_drain("len0");

      // LEN=15 GAP=0: fifteen ones then DONE.
      LEN = 4'd15; GAP = 4'd0; START = 1'b1;
      push_n(3'b110, 15); push(3'b011); push(3'b000);
      @(negedge CLK);
      START = 1'b0;
      wait_drain("len15");

      // START held high: bursts separated by one IDLE cycle; mid-burst LEN/GAP changes ignored.
      LEN = 4'd2; GAP = 4'd1; START = 1'b1;
      push(3'b110); push(3'b110); push(3'b010); push(3'b011); push(3'b000);
      push(3'b110); push(3'b110); push(3'b010); push(3'b011); push(3'b000);
      push(3'b000);
      for (int i = 1; i <= 6; i++) begin
         @(negedge CLK);
         if (i == 2) begin LEN = 4'd9; GAP = 4'd6; end
         if (i == 4) begin LEN = 4'd2; GAP = 4'd1; end
         if (i == 6) begin START = 1'b0; LEN = 4'd7; GAP = 4'd5; end
      end
      wait_drain("handshake");

      // Loopback through the detector: LEN=4 GAP=1 gives exactly two detector-high cycles.
      LEN = 4'd4; GAP = 4'd1; START = 1'b1;
      push_n(3'b110, 4); push(3'b010); push(3'b011); push(3'b000);
      @(negedge CLK);
      START = 1'b0;
      n_det = 0;
      for (int i = 0; i < 9; i++) begin
         @(posedge CLK);
         #2;
         if (det) n_det++;
      end
      check("loopback_det_cycles", 3'(n_det), 3'd2);
      wait_drain("loopback");

`ifdef RUN_BURST_REPEAT_EN
      // Repeat: 1,1,0,FIN period 4 with BUSY held; dropping REPEAT ends after current FIN.
      @(negedge CLK);
      REPEAT = 1'b1; LEN = 4'd2; GAP = 4'd1; START = 1'b1;
      for (int b = 0; b < 3; b++) begin
         push(3'b110); push(3'b110); push(3'b010); push(3'b011);
      end
      push(3'b000); push(3'b000);
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         if (i == 1) START = 1'b0;
         if (i == 8) REPEAT = 1'b0;
      end
      wait_drain("repeat");
`endif

      // Asynchronous reset mid-burst: outputs drop at once and no DONE follows.
      @(negedge CLK);
      LEN = 4'd5; GAP = 4'd2; START = 1'b1;
      push_n(3'b110, 3);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check("async_reset", {SOUT, BUSY, DONE}, 3'b000);
      @(negedge CLK);
      RST = 1'b0;
      push_n(3'b000, 10);
      wait_drain("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got time %0t required finish earlier", $time);
      $fatal(1);
   end

endmodule
